// File: rtl/modport_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty flags.
// Optional status outputs (wcount, overflow, underflow) under MODPORT_FIFO_STATUS_EN.
module modport_fifo #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty
`ifdef MODPORT_FIFO_STATUS_EN
  ,
  output logic [ASIZE:0]   wcount,
  output logic             overflow,
  output logic             underflow
`endif
);

  localparam int DEPTH = 1 << ASIZE;
  localparam logic [ASIZE:0] FULL_OCC = {1'b1, {ASIZE{1'b0}}};

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr, rptr;
  logic [ASIZE:0]   wptr_nxt, rptr_nxt, occ_nxt;
  logic             wacc, racc;

  // A request is only honoured against the flags as they stand this cycle.
  assign wacc     = winc & ~wfull;
  assign racc     = rinc & ~rempty;
  assign wptr_nxt = wptr + {{ASIZE{1'b0}}, wacc};
  assign rptr_nxt = rptr + {{ASIZE{1'b0}}, racc};
  assign occ_nxt  = wptr_nxt - rptr_nxt;

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wptr   <= '0;
      rptr   <= '0;
      rempty <= 1'b1;
      wfull  <= 1'b0;
    end else begin
      wptr   <= wptr_nxt;
      rptr   <= rptr_nxt;
      rempty <= (occ_nxt == '0);
      wfull  <= (occ_nxt == FULL_OCC);
    end
  end

  // Storage carries no reset; stale words are unreachable once pointers clear.
  always_ff @(posedge wclk) begin
    if (wacc) mem[wptr[ASIZE-1:0]] <= wdata;
  end

  assign rdata = rempty ? '0 : mem[rptr[ASIZE-1:0]];

`ifdef MODPORT_FIFO_STATUS_EN
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wcount    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      wcount    <= occ_nxt;
      overflow  <= overflow  | (winc & wfull);
      underflow <= underflow | (rinc & rempty);
    end
  end
`endif

endmodule

// File: tb/tb_modport_fifo.sv
// Directed scoreboard bench for modport_fifo: queue model of accepted words,
// flags and head data checked every step with immediate assertions.
module tb_modport_fifo;

  localparam int DSIZE = 8;
  localparam int ASIZE = 4;
  localparam int DEPTH = 16;

  logic             wclk = 1'b0;
  logic             wrst;
  logic [DSIZE-1:0] wdata;
  logic             winc, rinc;
  logic [DSIZE-1:0] rdata;
  logic             wfull, rempty;
`ifdef MODPORT_FIFO_STATUS_EN
  logic [ASIZE:0]   wcount;
  logic             overflow, underflow;
  bit               m_ovf, m_unf;
`endif

  int compared = 0;
  int mismatched = 0;
  logic [DSIZE-1:0] q[$];

  modport_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
    .wclk   (wclk),
    .wrst   (wrst),
    .wdata  (wdata),
    .winc   (winc),
    .rinc   (rinc),
    .rdata  (rdata),
    .wfull  (wfull),
    .rempty (rempty)
`ifdef MODPORT_FIFO_STATUS_EN
    ,
    .wcount   (wcount),
    .overflow (overflow),
    .underflow(underflow)
`endif
  );

  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, ":rempty"}, {31'd0, rempty}, {31'd0, q.size() == 0});
    check({tag, ":wfull"},  {31'd0, wfull},  {31'd0, q.size() == DEPTH});
`ifdef MODPORT_FIFO_STATUS_EN
    check({tag, ":wcount"},    {27'd0, wcount},    q.size());
    check({tag, ":overflow"},  {31'd0, overflow},  {31'd0, m_ovf});
    check({tag, ":underflow"}, {31'd0, underflow}, {31'd0, m_unf});
`endif
  endtask

  // One clock of stimulus; head data checked before the edge, flags after.
  task automatic step(input string tag, input logic w, input logic [DSIZE-1:0] d, input logic r);
    bit wacc, racc;
    winc  = w;
    wdata = d;
    rinc  = r;
    wacc  = w && (q.size() != DEPTH);
    racc  = r && (q.size() != 0);
    if (q.size() == 0) check({tag, ":rdata_empty"}, {24'd0, rdata}, 32'd0);
    else               check({tag, ":rdata_head"},  {24'd0, rdata}, {24'd0, q[0]});
`ifdef MODPORT_FIFO_STATUS_EN
    if (w && q.size() == DEPTH) m_ovf = 1'b1;
    if (r && q.size() == 0)     m_unf = 1'b1;
`endif
    @(posedge wclk);
    #1;
    if (racc) void'(q.pop_front());
    if (wacc) q.push_back(d);
    winc = 1'b0;
    rinc = 1'b0;
    check_flags(tag);
  endtask

  initial begin
    wrst  = 1'b1;
    winc  = 1'b0;
    rinc  = 1'b0;
    wdata = '0;
    #2;
    check("reset:rempty", {31'd0, rempty}, 32'd1);
    check("reset:wfull",  {31'd0, wfull},  32'd0);
    check("reset:rdata",  {24'd0, rdata},  32'd0);
    repeat (2) @(posedge wclk);
    #1;
    wrst = 1'b0;

    // Three-word write then read-back
    step("w11", 1'b1, 8'h11, 1'b0);
    check("first_head", {24'd0, rdata}, 32'h11);
    step("w22", 1'b1, 8'h22, 1'b0);
    step("w33", 1'b1, 8'h33, 1'b0);
    for (int i = 0; i < 3; i++) step("rd3", 1'b0, 8'h00, 1'b1);

    // Read from empty is ignored
    step("rd_empty", 1'b0, 8'h00, 1'b1);

    // Fill to full, drop a 17th write, drain
    for (int i = 0; i < DEPTH; i++) step("fill", 1'b1, 8'(i), 1'b0);
    step("wr_full_drop", 1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, 8'h00, 1'b1);

    // Half full, then concurrent read/write across pointer wrap
    for (int i = 0; i < 8; i++) step("half", 1'b1, 8'(8'h40 + i), 1'b0);
    for (int i = 0; i < 40; i++) step("rw_wrap", 1'b1, 8'(8'h80 + i), 1'b1);
    check("wrap_occ", q.size(), 32'd8);
    for (int i = 0; i < 8; i++) step("drain8", 1'b0, 8'h00, 1'b1);

    // Full with both requests: read only
    for (int i = 0; i < DEPTH; i++) step("fill2", 1'b1, 8'(8'hC0 + i), 1'b0);
    step("full_rw", 1'b1, 8'hEE, 1'b1);
    check("full_rw_occ", q.size(), 32'd15);
    for (int i = 0; i < 15; i++) step("drain15", 1'b0, 8'h00, 1'b1);

    // Empty with both requests: write only
    step("empty_rw", 1'b1, 8'h5A, 1'b1);
    check("empty_rw_head", {24'd0, rdata}, 32'h5A);
    step("rd_5a", 1'b0, 8'h00, 1'b1);

    // Asynchronous reset with five words held
    for (int i = 0; i < 5; i++) step("pre_rst", 1'b1, 8'(8'h60 + i), 1'b0);
    #2;
    wrst = 1'b1;
    #1;
    check("async_rst:rempty", {31'd0, rempty}, 32'd1);
    check("async_rst:wfull",  {31'd0, wfull},  32'd0);
    check("async_rst:rdata",  {24'd0, rdata},  32'd0);
    q.delete();
`ifdef MODPORT_FIFO_STATUS_EN
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_flags("async_rst");
`endif
    @(posedge wclk);
    #3;
    wrst = 1'b0;
    step("post_rst_wr", 1'b1, 8'hA5, 1'b0);
    step("post_rst_rd", 1'b0, 8'h00, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/modport_fifo.md
MODPORT_FIFO -- requirements
Module: modport_fifo

Interface
REQ-001 Parameter DSIZE, default 8, data word width in bits.
REQ-002 Parameter ASIZE, default 4, address width; depth = 2**ASIZE (16 words).
REQ-003 wclk  input  1  sole clock; all state updates on rising edge.
REQ-004 wrst  input  1  reset, asynchronous, active-high; one clock, one reset domain.
REQ-005 wdata  input  DSIZE  write data.
REQ-006 winc  input  1  write request.
REQ-007 rinc  input  1  read request.
REQ-008 rdata  output  DSIZE  head-of-queue data.
REQ-009 wfull  output  1  FIFO holds 2**ASIZE words.
REQ-010 rempty  output  1  FIFO holds 0 words.

Function
REQ-011 Write accepted on a rising edge when winc=1 and wfull=0: wdata stored at write pointer; pointer +1.
REQ-012 winc=1 while wfull=1: write dropped, no state change.
REQ-013 Read accepted on a rising edge when rinc=1 and rempty=0: read pointer +1.
REQ-014 rinc=1 while rempty=1: read ignored, no state change.
REQ-015 rdata is first-word fall-through, driven combinationally from the entry at the read pointer; valid whenever rempty=0, 0 whenever rempty=1.
REQ-016 Pointers are ASIZE+1 bits; memory indexed by the low ASIZE bits; wrap-around from 2**ASIZE-1 to 0 is seamless.
REQ-017 Occupancy = wptr - rptr, modulo 2**(ASIZE+1), range 0..2**ASIZE.
REQ-018 Registered flags: rempty=1 iff occupancy 0 and wfull=1 iff occupancy 2**ASIZE, both valid in the cycle after the edge that changed occupancy.
REQ-019 Simultaneous accepted read and write: occupancy unchanged; flags unchanged.
REQ-020 Full with winc=1 and rinc=1: only the read is accepted; wfull clears next cycle.
REQ-021 Empty with winc=1 and rinc=1: only the write is accepted; rempty clears next cycle; written word then appears on rdata.
REQ-022 Data emerges strictly in write order; no loss or duplication of accepted words.

Reset
REQ-023 wrst=1 immediately, without a clock edge: pointers 0, rempty=1, wfull=0, rdata=0.
REQ-024 Memory contents are not cleared; data in flight at reset is discarded.
REQ-025 First write accepted on the first rising edge after wrst deasserts.

Configuration
REQ-026 Macro MODPORT_FIFO_STATUS_EN defined: adds outputs wcount [ASIZE:0] (occupancy, registered), overflow (1 bit) and underflow (1 bit).
REQ-027 overflow sets on any edge with winc=1 and wfull=1; underflow sets on any edge with rinc=1 and rempty=1; both are sticky and cleared only by wrst; all three reset to 0.
REQ-028 Macro undefined: these ports and their logic are absent; REQ-001..025 behaviour is identical.

Verification
REQ-029 Reset, then write 0x11,0x22,0x33 on consecutive edges -> rempty=0 after the first write, rdata=0x11; three reads return 0x11,0x22,0x33; rempty=1 after the third.
REQ-030 Write 16 words 0x00..0x0F -> wfull=1 after the 16th; 17th write of 0xFF is dropped; 16 reads return 0x00..0x0F; rempty=1.
REQ-031 Fill to 8 words, then hold winc=rinc=1 for 40 cycles (pointer wrap) -> occupancy stays 8, flags stay 0, output order matches input order.
REQ-032 Full with winc=rinc=1 -> one word read, none written, wfull=0 next cycle; empty with winc=rinc=1 -> one word written, rempty=0 next cycle.
REQ-033 Assert wrst mid-operation with 5 words stored -> rempty=1, wfull=0, rdata=0 immediately; subsequent write/read of 0xA5 returns 0xA5.
REQ-034 With MODPORT_FIFO_STATUS_EN: read when empty -> underflow=1 and stays 1; write when full -> overflow=1; wcount tracks 0..16; wrst clears all three.
